// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings and control-bundle layout for the ID/EX stage
package id_ex_stage_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       jal;
    logic [3:0] alu_op;
  } ctrl_t;
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idx_t;
endpackage

// File: rtl/id_ex_stage_hazard_detection_unit.sv
// hazard_detection_unit: combinational load-use detection with flush override
module hazard_detection_unit
  import id_ex_stage_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write
);
  assign stall       = ex_mem_read && (ex_rt != REG_ZERO) && (ex_rt == id_rs || ex_rt == id_rt) && !flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and stall counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic [REG_W-1:0] IF_ID_Rd,
  input  logic [N-1:0]     ReadData1,
  input  logic [N-1:0]     ReadData2,
  input  logic [N-1:0]     SignExtImm,
  input  logic [N-1:0]     PC4,
  input  logic             RegWrite_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             MemtoReg_i,
  input  logic             ALUSrc_i,
  input  logic             RegDst_i,
  input  logic             Jal_i,
  input  logic [3:0]       ALUOp_i,
  input  logic             Flush,
  output logic [REG_W-1:0] ID_EX_Rs,
  output logic [REG_W-1:0] ID_EX_Rt,
  output logic [REG_W-1:0] ID_EX_Rd,
  output logic [N-1:0]     ID_EX_ReadData1,
  output logic [N-1:0]     ID_EX_ReadData2,
  output logic [N-1:0]     ID_EX_Imm,
  output logic [N-1:0]     ID_EX_PC4,
  output logic             ID_EX_RegWrite,
  output logic             ID_EX_MemRead,
  output logic             ID_EX_MemWrite,
  output logic             ID_EX_MemtoReg,
  output logic             ID_EX_ALUSrc,
  output logic             ID_EX_RegDst,
  output logic             ID_EX_Jal,
  output logic [3:0]       ID_EX_ALUOp,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);
  ctrl_t          ctrl_q;
  idx_t           idx_q;
  logic [N-1:0]   rd1_q, rd2_q, imm_q, pc4_q;
  logic           bubble;
  hazard_detection_unit u_hdu (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (idx_q.rt),
    .id_rs       (IF_ID_Rs),
    .id_rt       (IF_ID_Rt),
    .flush       (Flush),
    .stall       (Stall),
    .pc_write    (PCWrite),
    .if_id_write (IF_ID_Write)
  );
  assign bubble = Flush || Stall;
  // Latch the ID bundle, or zero everything so a bubble can never write or forward
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      idx_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc4_q      <= '0;
      StallCount <= '0;
    end else begin
      ctrl_q     <= bubble ? '0 : {RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, RegDst_i, Jal_i, ALUOp_i};
      idx_q      <= bubble ? '0 : {IF_ID_Rs, IF_ID_Rt, IF_ID_Rd};
      rd1_q      <= bubble ? '0 : ReadData1;
      rd2_q      <= bubble ? '0 : ReadData2;
      imm_q      <= bubble ? '0 : SignExtImm;
      pc4_q      <= bubble ? '0 : PC4;
      StallCount <= (Stall && StallCount != '1) ? StallCount + CNT_W'(1) : StallCount;
    end
  end
  assign ID_EX_Rs        = idx_q.rs;
  assign ID_EX_Rt        = idx_q.rt;
  assign ID_EX_Rd        = idx_q.rd;
  assign ID_EX_ReadData1 = rd1_q;
  assign ID_EX_ReadData2 = rd2_q;
  assign ID_EX_Imm       = imm_q;
  assign ID_EX_PC4       = pc4_q;
  assign ID_EX_RegWrite  = ctrl_q.reg_write;
  assign ID_EX_MemRead   = ctrl_q.mem_read;
  assign ID_EX_MemWrite  = ctrl_q.mem_write;
  assign ID_EX_MemtoReg  = ctrl_q.mem_to_reg;
  assign ID_EX_ALUSrc    = ctrl_q.alu_src;
  assign ID_EX_RegDst    = ctrl_q.reg_dst;
  assign ID_EX_Jal       = ctrl_q.jal;
  assign ID_EX_ALUOp     = ctrl_q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a pipeline-slot model
module tb_id_ex_stage;
  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm, pc4;
    logic        rw, mr, mw, m2r, as, rdst, jal;
    logic [3:0]  op;
  } st_t;
  logic clk = 0, reset = 0, flush = 0;
  st_t  in_v = '0, obs, obs2, m_q = '0;
  int   n_chk = 0, n_fail = 0;
  int unsigned m_cnt = 0, m_cnt2 = 0;
  logic        Stall, PCWrite, IF_ID_Write, Stall2, PCWrite2, IF_ID_Write2;
  logic [15:0] StallCount;
  logic [1:0]  StallCount2;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(in_v.rs), .IF_ID_Rt(in_v.rt), .IF_ID_Rd(in_v.rd),
    .ReadData1(in_v.d1), .ReadData2(in_v.d2), .SignExtImm(in_v.imm), .PC4(in_v.pc4),
    .RegWrite_i(in_v.rw), .MemRead_i(in_v.mr), .MemWrite_i(in_v.mw), .MemtoReg_i(in_v.m2r),
    .ALUSrc_i(in_v.as), .RegDst_i(in_v.rdst), .Jal_i(in_v.jal), .ALUOp_i(in_v.op), .Flush(flush),
    .ID_EX_Rs(obs.rs), .ID_EX_Rt(obs.rt), .ID_EX_Rd(obs.rd),
    .ID_EX_ReadData1(obs.d1), .ID_EX_ReadData2(obs.d2), .ID_EX_Imm(obs.imm), .ID_EX_PC4(obs.pc4),
    .ID_EX_RegWrite(obs.rw), .ID_EX_MemRead(obs.mr), .ID_EX_MemWrite(obs.mw), .ID_EX_MemtoReg(obs.m2r),
    .ID_EX_ALUSrc(obs.as), .ID_EX_RegDst(obs.rdst), .ID_EX_Jal(obs.jal), .ID_EX_ALUOp(obs.op),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .Stall(Stall), .StallCount(StallCount)
  );
  id_ex_stage #(.N(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(in_v.rs), .IF_ID_Rt(in_v.rt), .IF_ID_Rd(in_v.rd),
    .ReadData1(in_v.d1), .ReadData2(in_v.d2), .SignExtImm(in_v.imm), .PC4(in_v.pc4),
    .RegWrite_i(in_v.rw), .MemRead_i(in_v.mr), .MemWrite_i(in_v.mw), .MemtoReg_i(in_v.m2r),
    .ALUSrc_i(in_v.as), .RegDst_i(in_v.rdst), .Jal_i(in_v.jal), .ALUOp_i(in_v.op), .Flush(flush),
    .ID_EX_Rs(obs2.rs), .ID_EX_Rt(obs2.rt), .ID_EX_Rd(obs2.rd),
    .ID_EX_ReadData1(obs2.d1), .ID_EX_ReadData2(obs2.d2), .ID_EX_Imm(obs2.imm), .ID_EX_PC4(obs2.pc4),
    .ID_EX_RegWrite(obs2.rw), .ID_EX_MemRead(obs2.mr), .ID_EX_MemWrite(obs2.mw), .ID_EX_MemtoReg(obs2.m2r),
    .ID_EX_ALUSrc(obs2.as), .ID_EX_RegDst(obs2.rdst), .ID_EX_Jal(obs2.jal), .ID_EX_ALUOp(obs2.op),
    .PCWrite(PCWrite2), .IF_ID_Write(IF_ID_Write2), .Stall(Stall2), .StallCount(StallCount2)
  );
  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic bit model_stall();
    return m_q.mr && m_q.rt != 0 && (m_q.rt == in_v.rs || m_q.rt == in_v.rt) && !flush;
  endfunction
  task automatic cycle();
    bit s;
    #1;
    s = model_stall();
    check("stall", Stall, s);
    check("pcwrite", PCWrite, !s);
    check("if_id_write", IF_ID_Write, !s);
    check("stall_small", Stall2, s);
    @(posedge clk);
    m_q = (flush || s) ? '0 : in_v;
    if (s && m_cnt < 65535) m_cnt++;
    if (s && m_cnt2 < 3) m_cnt2++;
    @(negedge clk);
    check("regs", obs, m_q);
    check("regs_small", obs2, m_q);
    check("count", StallCount, m_cnt);
    check("count_small", StallCount2, m_cnt2);
  endtask
  function automatic st_t instr(input int rs, input int rt, input int rd, input bit mr, input bit rw);
    st_t v = '0;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.mr = mr; v.rw = rw;
    v.d1 = 32'h100 + 32'(rs); v.d2 = 32'h200 + 32'(rt); v.imm = 32'hffff_fff0; v.pc4 = 32'h40;
    return v;
  endfunction
  int sat_exp[5] = '{1, 2, 3, 3, 3};
  initial begin
    #2;
    check("reset_regs", obs, '0);
    check("reset_count", StallCount, 0);
    check("reset_pcwrite", PCWrite, 1);
    @(negedge clk);
    reset = 1;
    in_v = '0; in_v.rs = 3; in_v.rt = 4; in_v.rd = 5; in_v.d1 = 32'h11; in_v.rw = 1; in_v.op = 4'd2;
    cycle();
    check("pt_rs", obs.rs, 3);
    check("pt_rd", obs.rd, 5);
    check("pt_rd1", obs.d1, 32'h11);
    check("pt_rw_op", {obs.rw, obs.op}, {1'b1, 4'd2});
    in_v = instr(1, 8, 0, 1, 1);
    cycle();
    in_v = instr(8, 2, 3, 0, 1);
    #1 check("lu_stall", Stall, 1);
    check("lu_pcwrite", PCWrite, 0);
    check("lu_ifid", IF_ID_Write, 0);
    cycle();
    check("lu_bubble_ctrl", {obs.rw, obs.mr, obs.mw, obs.m2r, obs.as, obs.rdst, obs.jal, obs.op}, 0);
    check("lu_count", StallCount, 1);
    cycle();
    check("lu_dep_rs", obs.rs, 8);
    in_v = instr(1, 0, 0, 1, 1);
    cycle();
    in_v = instr(0, 0, 3, 0, 1);
    #1 check("zero_no_stall", Stall, 0);
    cycle();
    in_v = instr(1, 9, 0, 1, 1);
    cycle();
    in_v = instr(8, 10, 3, 0, 1);
    #1 check("nomatch_no_stall", Stall, 0);
    cycle();
    in_v = instr(1, 8, 0, 1, 1);
    cycle();
    in_v = instr(8, 8, 3, 0, 1); flush = 1;
    #1 check("flush_stall", Stall, 0);
    check("flush_pcwrite", PCWrite, 1);
    cycle();
    check("flush_bubble", obs, '0);
    check("flush_count", StallCount, 1);
    flush = 0;
    in_v = instr(2, 8, 0, 1, 1);
    cycle();
    in_v = instr(8, 3, 4, 0, 1); in_v.d1 = 32'hdead_beef;
    #2 reset = 0;
    #1 check("mid_reset_regs", obs, '0);
    check("mid_reset_count", StallCount, 0);
    check("mid_reset_pcwrite", PCWrite, 1);
    m_q = '0; m_cnt = 0; m_cnt2 = 0;
    @(negedge clk);
    reset = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      in_v = instr(1, 7, 0, 1, 1);
      cycle();
      in_v = instr(7, 2, 3, 0, 1);
      cycle();
      check("sat_count", StallCount2, sat_exp[i]);
    end
    for (int i = 0; i < 300; i++) begin
      in_v.rs = 5'($urandom_range(0, 3)); in_v.rt = 5'($urandom_range(0, 3)); in_v.rd = 5'($urandom);
      in_v.d1 = $urandom; in_v.d2 = $urandom; in_v.imm = $urandom; in_v.pc4 = $urandom;
      {in_v.rw, in_v.mr, in_v.mw, in_v.m2r, in_v.as, in_v.rdst, in_v.jal} = 7'($urandom);
      in_v.op = 4'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
